axi_read_arbiter: RTL

Shares the single `AXI_memory_master_burst` read port between two burst-read requesters. Requester 0 is the noise-estimation memory reader; requester 1 is the Wiener-filter memory reader. The block latches each requester's `start_read` pulse and its burst parameters, and grants the port round-robin. It replays the winner's request to the master, gates `rvalid` back to the owner, and signals completion on the `rlast` beat. Only one burst is ever outstanding.

---
 rtl/axi_read_arbiter.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/axi_read_arbiter.sv
// axi_read_arbiter
//   Shares one burst-read master port between two requesters
//   (0: noise-estimation reader, 1: Wiener-filter reader).
//   Each start_read pulse and its burst parameters are latched per requester.
//   The port is granted round-robin, with one burst outstanding at a time.
//   rvalid is routed back to the owner, and done is pulsed after the rlast beat.
// Ports
//   clk, rst_n            clock, async active-low reset
//   reqN_start_read/addr/len/size/burst   request pulse + burst params
//   reqN_pending/done/rvalid              per-requester status
//   rvalid, rready, rlast                 monitored read data channel
//   start_read, read_*                    command to the master
//   grant                                 one-hot owner, 00 when idle
// Optional: define AXI_RD_ARB_STATS_EN to add grant_cnt0/grant_cnt1
//   (saturating 16-bit per-requester grant counters).
module axi_read_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_start_read,
  input  logic [ADDR_WIDTH-1:0] req0_read_addr,
  input  logic [LEN_WIDTH-1:0]  req0_read_len,
  input  logic [2:0]            req0_read_size,
  input  logic [1:0]            req0_read_burst,
  output logic                  req0_pending,
  output logic                  req0_done,
  output logic                  req0_rvalid,
  input  logic                  req1_start_read,
  input  logic [ADDR_WIDTH-1:0] req1_read_addr,
  input  logic [LEN_WIDTH-1:0]  req1_read_len,
  input  logic [2:0]            req1_read_size,
  input  logic [1:0]            req1_read_burst,
  output logic                  req1_pending,
  output logic                  req1_done,
  output logic                  req1_rvalid,
  input  logic                  rvalid,
  input  logic                  rready,
  input  logic                  rlast,
  output logic                  start_read,
  output logic [ADDR_WIDTH-1:0] read_addr,
  output logic [LEN_WIDTH-1:0]  read_len,
  output logic [2:0]            read_size,
  output logic [1:0]            read_burst,
  output logic [1:0]            grant
`ifdef AXI_RD_ARB_STATS_EN
  ,
  output logic [15:0]           grant_cnt0,
  output logic [15:0]           grant_cnt1
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY} state_e;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [LEN_WIDTH-1:0]  len;
    logic [2:0]            size;
    logic [1:0]            burst;
  } cmd_t;

  state_e          state_q, state_d;
  logic [1:0]      pend_q, pend_d;
  cmd_t [1:0]      req_cmd_q, req_cmd_d;
  cmd_t            cmd_q, cmd_d;
  logic [1:0]      grant_q, grant_d;
  logic            start_q, start_d;
  logic [1:0]      done_q, done_d;
  logic            last_q, last_d;   // requester served most recently
  logic [1:0]      start_in;
  cmd_t [1:0]      req_in;
  logic            complete;
  logic            win1;

  assign start_in  = {req1_start_read, req0_start_read};
  assign req_in[0] = '{addr: req0_read_addr, len: req0_read_len,
                       size: req0_read_size, burst: req0_read_burst};
  assign req_in[1] = '{addr: req1_read_addr, len: req1_read_len,
                       size: req1_read_size, burst: req1_read_burst};

  // Completing beat only counts once the command phase is over.
  assign complete = (state_q == BUSY) & rvalid & rready & rlast;

  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    req_cmd_d = req_cmd_q;
    cmd_d     = cmd_q;
    grant_d   = grant_q;
    start_d   = 1'b0;
    done_d    = 2'b00;
    last_d    = last_q;
    win1      = 1'b0;

    // Capture: a pulse while pending is dropped, including on the completing
    // beat, so the owner's flag simply clears on that edge.
    for (int n = 0; n < 2; n++) begin
      if (pend_q[n]) begin
        if (complete && grant_q[n]) pend_d[n] = 1'b0;
      end else if (start_in[n]) begin
        pend_d[n]    = 1'b1;
        req_cmd_d[n] = req_in[n];
      end
    end

    case (state_q)
      IDLE: begin
        if (|pend_q) begin
          // Req1 wins if alone, or if both wait and req0 was served last.
          win1    = pend_q[1] & (~pend_q[0] | ~last_q);
          grant_d = win1 ? 2'b10 : 2'b01;
          cmd_d   = win1 ? req_cmd_q[1] : req_cmd_q[0];
          start_d = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = BUSY;
      BUSY: begin
        if (complete) begin
          done_d  = grant_q;
          last_d  = grant_q[1];
          grant_d = 2'b00;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pend_q    <= '0;
      req_cmd_q <= '0;
      cmd_q     <= '0;
      grant_q   <= '0;
      start_q   <= 1'b0;
      done_q    <= '0;
      last_q    <= 1'b1;   // so requester 0 wins the first tie
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      req_cmd_q <= req_cmd_d;
      cmd_q     <= cmd_d;
      grant_q   <= grant_d;
      start_q   <= start_d;
      done_q    <= done_d;
      last_q    <= last_d;
    end
  end

  assign req0_pending = pend_q[0];
  assign req1_pending = pend_q[1];
  assign req0_done    = done_q[0];
  assign req1_done    = done_q[1];
  assign req0_rvalid  = rvalid & grant_q[0] & (state_q == BUSY);
  assign req1_rvalid  = rvalid & grant_q[1] & (state_q == BUSY);
  assign start_read   = start_q;
  assign read_addr    = cmd_q.addr;
  assign read_len     = cmd_q.len;
  assign read_size    = cmd_q.size;
  assign read_burst   = cmd_q.burst;
  assign grant        = grant_q;

`ifdef AXI_RD_ARB_STATS_EN
  logic [1:0][15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    for (int n = 0; n < 2; n++)
      if (state_q == ISSUE && grant_q[n] && cnt_q[n] != 16'hFFFF)
        cnt_d[n] = cnt_q[n] + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign grant_cnt0 = cnt_q[0];
  assign grant_cnt1 = cnt_q[1];
`endif

endmodule
